// File: rtl/rotor_inverse_if.sv
// Letter stream interface for the return-path rotor: input strobe/letter in,
// mapped letter with done pulse and ready status out.
interface rotor_inverse_if #(
   parameter int DW = 8
);
   logic          valid;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          done;
   logic          ready;

   modport master (output valid, din, input dout, done, ready);
   modport slave  (input valid, din, output dout, done, ready);
endinterface

// File: rtl/rotor_inverse.sv
// Return-path Enigma rotor: builds the inverse of the forward wiring serially,
// then maps reflector letters through it at the current rotor position.
module rotor_inverse #(
   parameter int N_LETTERS = 26,
   parameter int DW        = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     set,
   input  logic [N_LETTERS*DW-1:0]  idx_in,
   input  logic [DW-1:0]            offset,
   input  logic                     rot,
   rotor_inverse_if.slave           bus,
   output logic                     cfg_err,
   output logic                     wrap
);
   localparam int PW = $clog2(N_LETTERS);
   localparam logic [DW-1:0] NL_D  = DW'(N_LETTERS);
   localparam logic [PW:0]   NL_W  = (PW+1)'(N_LETTERS);
   localparam logic [PW-1:0] LAST  = PW'(N_LETTERS - 1);

   typedef enum logic [1:0] {IDLE, BUILD, READY, ERROR} state_t;

   state_t        state;
   logic [PW-1:0] pos;
   logic [PW-1:0] k;
   logic [N_LETTERS-1:0] seen;
   logic [DW-1:0] tbl [N_LETTERS];
   logic [PW-1:0] inv [N_LETTERS];
   logic          bad;
   logic          ready_q;
   logic          done_q;
   logic [DW-1:0] dout_q;

   logic          s1_vld, s2_vld;
   logic          s1_pass, s2_pass;
   logic [DW-1:0] s1_raw, s2_raw;
   logic [PW-1:0] s1_t, s1_pos, s2_u, s2_pos;

   logic [DW-1:0] e_cur;
   logic          e_bad;
   logic          pass_in;
   logic [PW:0]   sum_in;
   logic [PW-1:0] t_in;
   logic [PW:0]   diff;

   always_comb begin
      e_cur   = tbl[k];
      e_bad   = (e_cur >= NL_D) || seen[e_cur[PW-1:0]];
      pass_in = bus.din >= NL_D;
      sum_in  = {1'b0, bus.din[PW-1:0]} + {1'b0, pos};
      t_in    = '0;
      if (!pass_in)
         t_in = (sum_in >= NL_W) ? PW'(sum_in - NL_W) : sum_in[PW-1:0];
      diff = {1'b0, s2_u} - {1'b0, s2_pos};
      if (s2_u < s2_pos)
         diff = diff + NL_W;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pos     <= '0;
         k       <= '0;
         seen    <= '0;
         bad     <= 1'b0;
         ready_q <= 1'b0;
         cfg_err <= 1'b0;
         wrap    <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
         s1_vld  <= 1'b0;
         s1_pass <= 1'b0;
         s1_raw  <= '0;
         s1_t    <= '0;
         s1_pos  <= '0;
         s2_vld  <= 1'b0;
         s2_pass <= 1'b0;
         s2_raw  <= '0;
         s2_u    <= '0;
         s2_pos  <= '0;
         for (int unsigned i = 0; i < N_LETTERS; i++) begin
            tbl[i] <= '0;
            inv[i] <= '0;
         end
      end else begin
         wrap   <= 1'b0;
         done_q <= 1'b0;
         if (set) begin
            for (int unsigned i = 0; i < N_LETTERS; i++)
               tbl[i] <= idx_in[i*DW +: DW];
            pos     <= offset[PW-1:0];
            bad     <= offset >= NL_D;
            seen    <= '0;
            k       <= '0;
            ready_q <= 1'b0;
            cfg_err <= 1'b0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            state   <= BUILD;
         end else begin
            if (rot && state != IDLE) begin
               pos  <= (pos == LAST) ? '0 : pos + 1'b1;
               wrap <= pos == LAST;
            end

            if (state == BUILD) begin
               if (e_bad)
                  bad <= 1'b1;
               else begin
                  inv[e_cur[PW-1:0]]  <= k;
                  seen[e_cur[PW-1:0]] <= 1'b1;
               end
               if (k == LAST) begin
                  if (bad || e_bad) begin
                     state   <= ERROR;
                     cfg_err <= 1'b1;
                  end else begin
                     state   <= READY;
                     ready_q <= 1'b1;
                  end
               end else
                  k <= k + 1'b1;
            end

            // Position travels with each letter so later steps cannot disturb it.
            s1_vld <= bus.valid && ready_q;
            if (bus.valid && ready_q) begin
               s1_pass <= pass_in;
               s1_raw  <= bus.din;
               s1_t    <= t_in;
               s1_pos  <= pos;
            end
            s2_vld  <= s1_vld;
            s2_pass <= s1_pass;
            s2_raw  <= s1_raw;
            s2_u    <= inv[s1_t];
            s2_pos  <= s1_pos;
            if (s2_vld) begin
               done_q <= 1'b1;
               dout_q <= s2_pass ? s2_raw : {{(DW-PW){1'b0}}, diff[PW-1:0]};
            end
         end
      end
   end

   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.dout  = dout_q;
endmodule

// File: tb/tb_rotor_inverse.sv
// Directed bench for rotor_inverse: identity and Rotor I wirings, offsets,
// wrap, configuration errors, reset mid-build, flush and passthrough.
module tb_rotor_inverse;
   localparam int N  = 26;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            reset, set, rot;
   logic [N*DW-1:0] idx_in;
   logic [DW-1:0]   offset;
   logic            cfg_err, wrap;
   int              checks = 0;
   int              errors = 0;
   logic [N*DW-1:0] ident, rot1, dup, bad30;

   rotor_inverse_if #(.DW(DW)) bus ();

   rotor_inverse #(.N_LETTERS(N), .DW(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .set     (set),
      .idx_in  (idx_in),
      .offset  (offset),
      .rot     (rot),
      .bus     (bus),
      .cfg_err (cfg_err),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input logic [N*DW-1:0] tbl, input logic [7:0] off);
      idx_in = tbl;
      offset = off;
      set    = 1'b1;
      tick;
      set    = 1'b0;
      repeat (26) tick;
   endtask

   task automatic letter(input string tag, input logic [7:0] d, input logic [7:0] exp);
      bus.valid = 1'b1;
      bus.din   = d;
      tick;
      bus.valid = 1'b0;
      tick;
      check({tag, "_early"}, 32'(bus.done), 32'd0);
      tick;
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_dout"}, 32'(bus.dout), 32'(exp));
   endtask

   function automatic logic [N*DW-1:0] from_str(input string s);
      logic [N*DW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         r[i*DW +: DW] = s[i] - 8'd65;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < N; i++)
         ident[i*DW +: DW] = 8'(i);
      rot1  = from_str("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
      dup   = rot1;
      dup[7*DW +: DW] = dup[2*DW +: DW];
      bad30 = ident;
      bad30[3*DW +: DW] = 8'd30;

      reset = 1'b1; set = 1'b0; rot = 1'b0;
      idx_in = '0; offset = '0;
      bus.valid = 1'b0; bus.din = '0;
      repeat (2) tick;
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_dout", 32'(bus.dout), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      reset = 1'b0;
      tick;

      // Identity: ready appears exactly 26 edges after set
      idx_in = ident; offset = 8'd0; set = 1'b1;
      tick;
      set = 1'b0;
      repeat (25) tick;
      check("ident_ready_k25", 32'(bus.ready), 32'd0);
      tick;
      check("ident_ready", 32'(bus.ready), 32'd1);
      check("ident_cfg_err", 32'(cfg_err), 32'd0);
      letter("ident_5", 8'd5, 8'd5);
      tick;
      check("ident_done_pulse", 32'(bus.done), 32'd0);
      check("ident_dout_hold", 32'(bus.dout), 32'd5);

      configure(rot1, 8'd0);
      letter("r1_a", 8'd0, 8'd20);
      letter("r1_e", 8'd4, 8'd0);

      // Offset 3, step in the same cycle as the letter
      configure(rot1, 8'd3);
      bus.valid = 1'b1; bus.din = 8'd0; rot = 1'b1;
      tick;
      bus.valid = 1'b0; rot = 1'b0;
      check("r1_off3_nowrap", 32'(wrap), 32'd0);
      tick;
      tick;
      check("r1_off3_done", 32'(bus.done), 32'd1);
      check("r1_off3_dout", 32'(bus.dout), 32'd3);
      letter("r1_pos4", 8'd0, 8'd22);

      configure(rot1, 8'd25);
      letter("r1_pos25", 8'd0, 8'd10);
      rot = 1'b1;
      tick;
      rot = 1'b0;
      check("wrap_pulse", 32'(wrap), 32'd1);
      tick;
      check("wrap_once", 32'(wrap), 32'd0);
      letter("r1_after_wrap", 8'd0, 8'd20);

      configure(dup, 8'd0);
      check("dup_cfg_err", 32'(cfg_err), 32'd1);
      check("dup_ready", 32'(bus.ready), 32'd0);
      bus.valid = 1'b1; bus.din = 8'd5;
      tick;
      bus.valid = 1'b0;
      tick; tick;
      check("dup_no_done", 32'(bus.done), 32'd0);
      configure(rot1, 8'd0);
      check("recover_ready", 32'(bus.ready), 32'd1);
      check("recover_cfg_err", 32'(cfg_err), 32'd0);

      configure(bad30, 8'd0);
      check("bad30_cfg_err", 32'(cfg_err), 32'd1);
      check("bad30_ready", 32'(bus.ready), 32'd0);
      configure(ident, 8'd26);
      check("off26_cfg_err", 32'(cfg_err), 32'd1);
      check("off26_ready", 32'(bus.ready), 32'd0);

      // Reset mid-build returns to idle and stays there
      idx_in = rot1; offset = 8'd0; set = 1'b1;
      tick;
      set = 1'b0;
      repeat (10) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("midrst_ready", 32'(bus.ready), 32'd0);
      check("midrst_cfg_err", 32'(cfg_err), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      repeat (30) tick;
      check("midrst_idle", 32'(bus.ready), 32'd0);
      rot = 1'b1;
      tick;
      rot = 1'b0;
      check("idle_rot_nowrap", 32'(wrap), 32'd0);

      // set with two letters in flight suppresses both results
      configure(rot1, 8'd0);
      bus.valid = 1'b1; bus.din = 8'd5;
      tick;
      bus.din = 8'd6;
      tick;
      bus.valid = 1'b0; set = 1'b1;
      tick;
      set = 1'b0;
      check("flush_done0", 32'(bus.done), 32'd0);
      tick;
      check("flush_done1", 32'(bus.done), 32'd0);
      tick;
      check("flush_done2", 32'(bus.done), 32'd0);
      repeat (24) tick;
      check("flush_ready", 32'(bus.ready), 32'd1);
      letter("space_pass", 8'd32, 8'd32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
